// File: rtl/turn_action_issuer.sv
// turn_action_issuer
//
// Turn controller for the two player FSMs. Each turn it collects one
// committed action code per player, presents both codes with an
// actionEnable strobe, waits a gap so the players can re-arm, and then
// samples both health values. When either health value reaches zero it
// latches game over and the winner until reset.
//
// Ports:
//   clk           single clock, rising edge
//   reset         synchronous, active-high
//   btn1_valid    one-cycle commit strobe, player 1
//   btn1_code     player 1 action code (kick 000 .. right2 111)
//   btn2_valid    one-cycle commit strobe, player 2
//   btn2_code     player 2 action code
//   health1/2     current player health (00 = dead)
//   action1/2     registered action codes presented to the players
//   actionEnable  high for ENABLE_CYCLES cycles per turn
//   isGameOver    sticky game-over flag
//   winner        00 none, 01 player 1, 10 player 2, 11 draw
//   turn_count    completed turns, saturating at 255
module turn_action_issuer #(
    parameter int TURN_TIMEOUT  = 1000,
    parameter int ENABLE_CYCLES = 4,
    parameter int GAP_CYCLES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn1_valid,
    input  logic [2:0] btn1_code,
    input  logic       btn2_valid,
    input  logic [2:0] btn2_code,
    input  logic [1:0] health1,
    input  logic [1:0] health2,
    output logic [2:0] action1,
    output logic [2:0] action2,
    output logic       actionEnable,
    output logic       isGameOver,
    output logic [1:0] winner,
    output logic [7:0] turn_count
);

    localparam logic [2:0] CODE_AWAIT = 3'b010;
    localparam int TW = (TURN_TIMEOUT  > 1) ? $clog2(TURN_TIMEOUT)  : 1;
    localparam int EW = (ENABLE_CYCLES > 1) ? $clog2(ENABLE_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES    > 1) ? $clog2(GAP_CYCLES)    : 1;

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_ISSUE   = 2'd1,
        S_GAP     = 2'd2,
        S_OVER    = 2'd3
    } state_t;

    state_t         state_reg, state_next;
    logic           commit1_reg, commit2_reg;
    logic [2:0]     code1_reg, code2_reg;
    logic [TW-1:0]  tcnt_reg;
    logic [EW-1:0]  ecnt_reg;
    logic [GW-1:0]  gcnt_reg;
    logic [2:0]     action1_reg, action2_reg;
    logic           enable_reg, over_reg;
    logic [1:0]     winner_reg;
    logic [7:0]     turn_count_reg;

    logic           take1, take2;
    logic           both_committed, timeout_hit, enable_last, gap_last;
    logic           health1_dead, health2_dead;
    logic [2:0]     issue_code1, issue_code2;

    always_comb begin
        take1 = (state_reg == S_COLLECT) && btn1_valid && !commit1_reg;
        take2 = (state_reg == S_COLLECT) && btn2_valid && !commit2_reg;
        // A strobe in the exit cycle counts, so commits are merged with the
        // live strobes before deciding and before choosing the issued code.
        both_committed = (commit1_reg || take1) && (commit2_reg || take2);
        issue_code1 = commit1_reg ? code1_reg : (take1 ? btn1_code : CODE_AWAIT);
        issue_code2 = commit2_reg ? code2_reg : (take2 ? btn2_code : CODE_AWAIT);
        timeout_hit  = (tcnt_reg == TW'(TURN_TIMEOUT - 1));
        enable_last  = (ecnt_reg == EW'(ENABLE_CYCLES - 1));
        gap_last     = (gcnt_reg == GW'(GAP_CYCLES - 1));
        health1_dead = (health1 == 2'b00);
        health2_dead = (health2 == 2'b00);
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_COLLECT: if (both_committed || timeout_hit) state_next = S_ISSUE;
            S_ISSUE:   if (enable_last) state_next = S_GAP;
            S_GAP: begin
                if (gap_last) begin
                    state_next = (health1_dead || health2_dead) ? S_OVER : S_COLLECT;
                end
            end
            S_OVER:    state_next = S_OVER;
            default:   state_next = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_COLLECT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            commit1_reg    <= 1'b0;
            commit2_reg    <= 1'b0;
            code1_reg      <= CODE_AWAIT;
            code2_reg      <= CODE_AWAIT;
            tcnt_reg       <= '0;
            ecnt_reg       <= '0;
            gcnt_reg       <= '0;
            action1_reg    <= CODE_AWAIT;
            action2_reg    <= CODE_AWAIT;
            enable_reg     <= 1'b0;
            over_reg       <= 1'b0;
            winner_reg     <= 2'b00;
            turn_count_reg <= 8'd0;
        end else begin
            case (state_reg)
                S_COLLECT: begin
                    if (take1) begin
                        commit1_reg <= 1'b1;
                        code1_reg   <= btn1_code;
                    end
                    if (take2) begin
                        commit2_reg <= 1'b1;
                        code2_reg   <= btn2_code;
                    end
                    tcnt_reg <= tcnt_reg + 1'b1;
                    if (state_next == S_ISSUE) begin
                        action1_reg <= issue_code1;
                        action2_reg <= issue_code2;
                        enable_reg  <= 1'b1;
                        ecnt_reg    <= '0;
                    end
                end
                S_ISSUE: begin
                    ecnt_reg <= ecnt_reg + 1'b1;
                    if (enable_last) begin
                        enable_reg <= 1'b0;
                        gcnt_reg   <= '0;
                    end
                end
                S_GAP: begin
                    gcnt_reg <= gcnt_reg + 1'b1;
                    if (gap_last) begin
                        if (health1_dead || health2_dead) begin
                            over_reg   <= 1'b1;
                            // bit 1: player 2 wins (player 1 dead); bit 0: player 1 wins
                            winner_reg <= {health1_dead, health2_dead};
                        end else begin
                            commit1_reg <= 1'b0;
                            commit2_reg <= 1'b0;
                            tcnt_reg    <= '0;
                            if (turn_count_reg != 8'hFF) begin
                                turn_count_reg <= turn_count_reg + 8'd1;
                            end
                        end
                    end
                end
                default: begin
                    // OVER: everything frozen until reset
                end
            endcase
        end
    end

    assign action1      = action1_reg;
    assign action2      = action2_reg;
    assign actionEnable = enable_reg;
    assign isGameOver   = over_reg;
    assign winner       = winner_reg;
    assign turn_count   = turn_count_reg;

endmodule

// File: tb/tb_turn_action_issuer.sv
// Directed testbench for turn_action_issuer (TURN_TIMEOUT=8, default
// enable/gap lengths). Inputs change 1 ns after a rising edge; outputs are
// sampled at the same point, after the edge's register updates.
module tb_turn_action_issuer;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn1_valid, btn2_valid;
    logic [2:0] btn1_code, btn2_code;
    logic [1:0] health1, health2;
    logic [2:0] action1, action2;
    logic       actionEnable, isGameOver;
    logic [1:0] winner;
    logic [7:0] turn_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    turn_action_issuer #(
        .TURN_TIMEOUT (8),
        .ENABLE_CYCLES(4),
        .GAP_CYCLES   (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn1_valid  (btn1_valid),
        .btn1_code   (btn1_code),
        .btn2_valid  (btn2_valid),
        .btn2_code   (btn2_code),
        .health1     (health1),
        .health2     (health2),
        .action1     (action1),
        .action2     (action2),
        .actionEnable(actionEnable),
        .isGameOver  (isGameOver),
        .winner      (winner),
        .turn_count  (turn_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
        $display("check %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_outs(input string tag, input logic [2:0] a1, input logic [2:0] a2,
                              input logic en, input logic ov, input logic [1:0] w,
                              input logic [7:0] tc);
        check({tag, ".action1"}, 8'(action1), 8'(a1));
        check({tag, ".action2"}, 8'(action2), 8'(a2));
        check({tag, ".enable"}, 8'(actionEnable), 8'(en));
        check({tag, ".over"}, 8'(isGameOver), 8'(ov));
        check({tag, ".winner"}, 8'(winner), 8'(w));
        check({tag, ".turns"}, 8'(turn_count), tc);
    endtask

    // Called right after the first actionEnable cycle has been checked:
    // three more enable cycles, then the two gap cycles. The caller sets
    // health before calling; the final edge (gap sample) is left to it.
    task automatic issue_and_gap(input string tag, input logic [2:0] a1, input logic [2:0] a2);
        for (int i = 0; i < 3; i++) begin
            tick();
            check({tag, ".en_hi"}, 8'(actionEnable), 8'd1);
            check({tag, ".a1_stable"}, 8'(action1), 8'(a1));
            check({tag, ".a2_stable"}, 8'(action2), 8'(a2));
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            check({tag, ".en_lo"}, 8'(actionEnable), 8'd0);
            check({tag, ".a1_hold"}, 8'(action1), 8'(a1));
        end
    endtask

    task automatic strobe(input logic v1, input logic [2:0] c1, input logic v2, input logic [2:0] c2);
        btn1_valid = v1; btn1_code = c1;
        btn2_valid = v2; btn2_code = c2;
        tick();
        btn1_valid = 1'b0; btn2_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        btn1_valid = 1'b0; btn1_code = 3'b000;
        btn2_valid = 1'b0; btn2_code = 3'b000;
        health1 = 2'b11; health2 = 2'b11;
        tick();
        tick();
        check_outs("reset", 3'b010, 3'b010, 1'b0, 1'b0, 2'b00, 8'd0);
        reset = 1'b0;

        // Idle: no enable for 7 cycles, timeout issues await/await on the 8th.
        for (int i = 0; i < 7; i++) begin
            tick();
            check("idle.enable", 8'(actionEnable), 8'd0);
        end
        tick();
        check_outs("timeout_idle", 3'b010, 3'b010, 1'b1, 1'b0, 2'b00, 8'd0);
        issue_and_gap("idle", 3'b010, 3'b010);
        tick();
        check_outs("turn1_done", 3'b010, 3'b010, 1'b0, 1'b0, 2'b00, 8'd1);

        // Both commit in the same cycle: enable on the very next cycle.
        strobe(1'b1, 3'b110, 1'b1, 3'b000);
        check_outs("both_commit", 3'b110, 3'b000, 1'b1, 1'b0, 2'b00, 8'd1);
        issue_and_gap("both", 3'b110, 3'b000);
        tick();
        check_outs("turn2_done", 3'b110, 3'b000, 1'b0, 1'b0, 2'b00, 8'd2);

        // Player 1 commits 001 then tries 000; player 2 silent -> timeout.
        strobe(1'b1, 3'b001, 1'b0, 3'b000);
        strobe(1'b1, 3'b000, 1'b0, 3'b000);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("p1only.enable", 8'(actionEnable), 8'd0);
        end
        tick();
        check_outs("first_commit_wins", 3'b001, 3'b010, 1'b1, 1'b0, 2'b00, 8'd2);
        issue_and_gap("p1only", 3'b001, 3'b010);
        tick();
        check_outs("turn3_done", 3'b001, 3'b010, 1'b0, 1'b0, 2'b00, 8'd3);

        // Player 2 strobes exactly on the timeout cycle: captured, not await.
        for (int i = 0; i < 7; i++) begin
            tick();
            check("late.enable", 8'(actionEnable), 8'd0);
        end
        strobe(1'b0, 3'b000, 1'b1, 3'b111);
        check_outs("strobe_on_timeout", 3'b010, 3'b111, 1'b1, 1'b0, 2'b00, 8'd3);
        health1 = 2'b01; health2 = 2'b00;
        issue_and_gap("late", 3'b010, 3'b111);
        tick();
        check_outs("p1_wins", 3'b010, 3'b111, 1'b0, 1'b1, 2'b01, 8'd3);

        // OVER ignores strobes and never re-enables, even past a timeout.
        btn1_valid = 1'b1; btn1_code = 3'b011;
        btn2_valid = 1'b1; btn2_code = 3'b100;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("over.enable", 8'(actionEnable), 8'd0);
        end
        btn1_valid = 1'b0; btn2_valid = 1'b0;
        check_outs("over_sticky", 3'b010, 3'b111, 1'b0, 1'b1, 2'b01, 8'd3);

        // Draw: both health 00.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_outs("reset2", 3'b010, 3'b010, 1'b0, 1'b0, 2'b00, 8'd0);
        health1 = 2'b00; health2 = 2'b00;
        strobe(1'b1, 3'b100, 1'b1, 3'b101);
        check_outs("draw_issue", 3'b100, 3'b101, 1'b1, 1'b0, 2'b00, 8'd0);
        issue_and_gap("draw", 3'b100, 3'b101);
        tick();
        check_outs("draw", 3'b100, 3'b101, 1'b0, 1'b1, 2'b11, 8'd0);

        // Player 2 wins: only health1 is 00.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        health1 = 2'b00; health2 = 2'b10;
        strobe(1'b1, 3'b001, 1'b1, 3'b011);
        check_outs("p2_issue", 3'b001, 3'b011, 1'b1, 1'b0, 2'b00, 8'd0);
        issue_and_gap("p2", 3'b001, 3'b011);
        tick();
        check_outs("p2_wins", 3'b001, 3'b011, 1'b0, 1'b1, 2'b10, 8'd0);

        // Reset during ISSUE cycle 2 aborts the turn.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        health1 = 2'b11; health2 = 2'b11;
        strobe(1'b1, 3'b101, 1'b1, 3'b011);
        check_outs("abort_issue1", 3'b101, 3'b011, 1'b1, 1'b0, 2'b00, 8'd0);
        tick();
        check("abort_issue2.enable", 8'(actionEnable), 8'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_outs("abort", 3'b010, 3'b010, 1'b0, 1'b0, 2'b00, 8'd0);
        // Back in COLLECT: a fresh single commit must not issue early.
        strobe(1'b1, 3'b000, 1'b0, 3'b000);
        check("abort_collect.enable", 8'(actionEnable), 8'd0);
        strobe(1'b0, 3'b000, 1'b1, 3'b110);
        check_outs("after_abort", 3'b000, 3'b110, 1'b1, 1'b0, 2'b00, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/turn_action_issuer.md
# turn_action_issuer

Turn controller that drives the action side of both player FSMs. It collects one committed action code per player per turn and presents both codes together with a multi-cycle `actionEnable` strobe. After the strobe it waits a gap so the players can re-arm, then samples both health values. It declares game over and the winner when either health reaches zero. It sits between the button/keypad decoding logic and the two player blocks, and is the only source of `action1`, `action2`, `actionEnable` and `isGameOver`.

## Interface
Parameters:
- `TURN_TIMEOUT`, default 1000: cycles allowed in COLLECT before uncommitted players are forced to `await`; must be ≥1.
- `ENABLE_CYCLES`, default 4: number of cycles `actionEnable` is held high per turn; must be ≥1.
- `GAP_CYCLES`, default 2: cycles `actionEnable` is low before health is sampled; must be ≥1.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `btn1_valid`  in  1  one-cycle commit strobe from player 1 input.
- `btn1_code`  in  3  player 1 action code: kick 000, punch 001, await 010, jump 011, left1 100, left2 101, right1 110, right2 111.
- `btn2_valid`  in  1  one-cycle commit strobe from player 2 input.
- `btn2_code`  in  3  player 2 action code, same encoding as `btn1_code`.
- `health1`  in  2  current health of player 1.
- `health2`  in  2  current health of player 2.
- `action1`  out  3  registered action code presented to the players for player 1.
- `action2`  out  3  registered action code presented to the players for player 2.
- `actionEnable`  out  1  registered strobe; high for exactly `ENABLE_CYCLES` cycles per turn.
- `isGameOver`  out  1  registered; sticky until reset.
- `winner`  out  2  00 none, 01 player 1 wins, 10 player 2 wins, 11 draw.
- `turn_count`  out  8  count of completed turns; saturates at 255.

## Operation
- States: COLLECT, ISSUE, GAP, OVER. Reset enters COLLECT.
- COLLECT:
  - Per-player commit flags and latched codes.
  - A `btnN_valid` is accepted only while in COLLECT and only if that player is not yet committed. The first commit wins; later strobes in the same turn are ignored.
  - A timeout counter starts at 0 on entry and increments every COLLECT cycle.
  - Exit to ISSUE on the cycle where both players are committed, counting strobes arriving in that cycle.
  - Also exit to ISSUE on the cycle the counter equals `TURN_TIMEOUT-1`.
  - On a timeout exit, a player still uncommitted is issued `await` (010). A strobe arriving on the timeout cycle is captured and takes priority over `await`.
- ISSUE:
  - `action1`/`action2` are loaded with the latched codes on the entry edge.
  - `actionEnable` is 1 throughout ISSUE. Both codes are stable for every cycle `actionEnable` is high.
  - After `ENABLE_CYCLES` cycles, go to GAP.
- GAP:
  - `actionEnable` is 0; `action1`/`action2` hold their values.
  - After `GAP_CYCLES` cycles, sample `health1`/`health2` on the last GAP cycle.
  - If either sampled value is 00, go to OVER. Otherwise go to COLLECT, clear commit flags and the timeout counter, and increment `turn_count` (saturating).
- OVER:
  - `isGameOver`=1.
  - `winner`: 01 if only `health2`==00, 10 if only `health1`==00, 11 if both are 00.
  - Button strobes are ignored and `actionEnable` stays 0.
  - Exit only by reset.
- Health values are used as delivered; no range checking.
- Reset mid-turn, in any state, aborts the turn immediately and discards latched codes.

## Timing
- Reset values:
  - `action1`=`action2`=010.
  - `actionEnable`=0, `isGameOver`=0, `winner`=00, `turn_count`=0.
  - Commit flags clear; timeout counter 0.
- Commit latency: the last commit is sampled at edge N, and `actionEnable` is 1 from cycle N+1 through N+`ENABLE_CYCLES`.
- Timeout latency: first `actionEnable`=1 appears `TURN_TIMEOUT` cycles after COLLECT entry.
- Turn length, strobe to strobe with immediate commits: `ENABLE_CYCLES`+`GAP_CYCLES`+1 cycles minimum.
- `isGameOver` and `winner` rise one cycle after the last GAP cycle. `turn_count` updates on the same edge as the return to COLLECT.
- Counter widths: `$clog2` of each parameter, at least 1 bit.

## Test plan
- Reset, then idle 10 cycles with no strobes → outputs at reset values; `actionEnable` stays 0 until a timeout.
- Both strobes in the same cycle (`btn1_code`=110, `btn2_code`=000), defaults → next cycle `action1`=110, `action2`=000, `actionEnable`=1 for exactly 4 cycles, then 0 for 2 cycles; `turn_count`=1 after.
- Player 1 commits 001 and then 000 in the same turn, player 2 never commits, `TURN_TIMEOUT`=8 → issue at cycle 8 with `action1`=001, `action2`=010.
- `btn2_valid` arriving on the timeout cycle with code 111 → `action2`=111, not 010.
- Health stubs return `health1`=01, `health2`=00 at the GAP sample → `isGameOver`=1, `winner`=01; later strobes produce no `actionEnable`. Repeat with both 00 → `winner`=11.
- Assert `reset` during ISSUE cycle 2 → next cycle `actionEnable`=0, `action1`=`action2`=010, state COLLECT, `turn_count`=0.
